instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: launches one word read per fetch_en, holds the PC while a
// read is outstanding, and drains flushed reads. Optional misalignment fault: FETCH_ALIGN_CHECK_EN.
module instr_fetch (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_val,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        pc_stall,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: mem_req and mem_addr are held stable from launch until the first cycle with
  // mem_ack=1; that cycle completes the read and mem_rdata is consumed only then.
  state_t      state_q, state_d;
  logic [31:2] addr_q;
  logic        launch_req;
  logic        bad_align;
  logic        launch;

  assign launch_req = fetch_en & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  assign bad_align = (pc_val[1:0] != 2'b00);
  assign misalign  = misalign_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      misalign_q <= 1'b0;
    end else if (flush) begin
      misalign_q <= 1'b0;
    end else if (launch_req) begin
      misalign_q <= bad_align;
    end
  end
`else
  // Low PC bits are dropped: the fetch address is always forced word-aligned.
  logic pc_low_unused;
  assign pc_low_unused = ^pc_val[1:0];
  assign bad_align     = 1'b0;
  assign misalign      = 1'b0;
`endif

  assign launch = launch_req & ~bad_align;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr   <= NOP;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q <= pc_val[31:2];
      end
      if ((state_q == S_REQ) && mem_ack && !flush) begin
        instr <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    pc_stall    = 1'b0;
    instr_valid = 1'b0;
    mem_addr    = {addr_q, 2'b00};
    case (state_q)
      S_IDLE: begin
        if (launch) state_d = S_REQ;
      end
      S_REQ: begin
        mem_req  = 1'b1;
        pc_stall = 1'b1;
        if (mem_ack) begin
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        instr_valid = ~flush;
        state_d     = launch ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        // The memory still owes a response; wait for it and throw it away.
        mem_req  = 1'b1;
        pc_stall = 1'b1;
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch, checked against a transaction-level
// model built from outstanding/discard flags.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc_val;
  logic        fetch_en;
  logic        flush;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pc_stall;
  logic        misalign;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int stall_seen = 0;

  // Reference model state
  logic        m_busy;
  logic        m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_instr;
  logic        m_vphase;
  logic        m_mis;
  logic [1:0]  st_reset;

  instr_fetch dut (
    .clk(clk), .clr(clr), .pc_val(pc_val), .fetch_en(fetch_en), .flush(flush),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .instr(instr), .instr_valid(instr_valid), .pc_stall(pc_stall), .misalign(misalign),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_discard = 0; m_addr = 0; m_instr = 32'h0000_0013; m_vphase = 0; m_mis = 0;
  endtask

  task automatic compare_all();
    check("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
    check("pc_stall", {31'b0, pc_stall}, {31'b0, m_busy});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_vphase & ~flush});
    check("instr", instr, m_instr);
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    if (m_busy) check("mem_addr", mem_addr, {m_addr[31:2], 2'b00});
    if (instr_valid) valid_seen++;
    if (pc_stall) stall_seen++;
  endtask

  task automatic model_update();
    logic bad;
`ifdef FETCH_ALIGN_CHECK_EN
    bad = (pc_val[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    if (m_busy) begin
      if (mem_ack) begin
        if (!m_discard && !flush) begin
          m_instr  = mem_rdata;
          m_vphase = 1;
        end
        m_busy = 0;
        m_discard = 0;
      end else if (flush) begin
        m_discard = 1;
      end
    end else begin
      m_vphase = 0;
      if (fetch_en && !flush) begin
        if (bad) begin
          m_mis = 1;
        end else begin
          m_busy = 1;
          m_addr = pc_val;
          m_mis  = 0;
        end
      end
    end
    if (flush) m_mis = 0;
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance the model at the rising edge.
  task automatic step(input logic fe, input logic fl, input logic ack,
                      input logic [31:0] pc, input logic [31:0] rd);
    fetch_en = fe; flush = fl; mem_ack = ack; pc_val = pc; mem_rdata = rd;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    clr = 1; fetch_en = 0; flush = 0; mem_ack = 0; pc_val = 0; mem_rdata = 0;
    model_reset();
    @(negedge clk);
    compare_all();
    st_reset = dbg_state;
    @(posedge clk); #1;
    clr = 0;

    // Single zero-wait fetch
    stall_seen = 0; valid_seen = 0;
    step(1, 0, 0, 32'h40, 0);
    step(0, 0, 1, 32'h40, 32'h0050_0093);
    step(0, 0, 0, 32'h40, 0);
    step(0, 0, 0, 32'h40, 0);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_valids", valid_seen, 1);
    check("t1_stall", stall_seen, 1);

    // Ack after three wait cycles
    stall_seen = 0; valid_seen = 0;
    step(1, 0, 0, 32'h80, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h84, 32'hFFFF_FFFF);
    step(0, 0, 1, 32'h84, 32'h1234_5678);
    step(0, 0, 0, 32'h84, 0);
    check("t2_stall", stall_seen, 4);
    check("t2_valids", valid_seen, 1);

    // Flush in REQ without ack, late ack discarded
    valid_seen = 0;
    step(1, 0, 0, 32'hC0, 0);
    step(0, 1, 0, 32'hC0, 0);
    step(1, 0, 0, 32'hC4, 0);
    step(0, 0, 1, 32'hC4, 32'hDEAD_BEEF);
    step(0, 0, 0, 32'hC4, 0);
    check("t3_instr", instr, 32'h1234_5678);
    check("t3_valids", valid_seen, 0);

    // Back-to-back fetches
    valid_seen = 0;
    step(1, 0, 0, 32'h100, 0);
    step(1, 0, 1, 32'h100, 32'hA0);
    step(1, 0, 0, 32'h104, 0);
    step(1, 0, 1, 32'h104, 32'hA4);
    step(1, 0, 0, 32'h108, 0);
    step(1, 0, 1, 32'h108, 32'hA8);
    step(0, 0, 0, 32'h108, 0);
    check("t4_valids", valid_seen, 3);
    check("t4_instr", instr, 32'hA8);

    // Flush and fetch together: no launch
    step(1, 1, 0, 32'h200, 0);
    step(0, 0, 0, 32'h200, 0);

    // Asynchronous reset mid-request
    step(1, 0, 0, 32'h300, 0);
    @(negedge clk);
    compare_all();
    #2 clr = 1;
    #1;
    model_reset();
    check("async_req", {31'b0, mem_req}, 32'h0);
    check("async_stall", {31'b0, pc_stall}, 32'h0);
    check("async_instr", instr, 32'h0000_0013);
    check("async_state", {30'b0, dbg_state}, {30'b0, st_reset});
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    clr = 0;
    step(0, 0, 1, 32'h300, 32'hBAD0_BAD0);
    step(0, 0, 0, 32'h300, 0);

`ifdef FETCH_ALIGN_CHECK_EN
    step(1, 0, 0, 32'h42, 0);
    step(0, 0, 0, 32'h42, 0);
    check("mis_set", {31'b0, misalign}, 32'h1);
    step(1, 0, 0, 32'h44, 0);
    step(0, 0, 1, 32'h44, 32'h44);
    check("mis_clear", {31'b0, misalign}, 32'h0);
    step(0, 0, 0, 32'h44, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
           pc, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
